afe_stream: RTL and testbench
=============================

AFE_STREAM -- requirements
Module: afe_stream

Interface
REQ-001 Parameter DEPTH, default 1024: number of words written per job (power of two, at least 2).
REQ-002 Parameter AW, default $clog2(DEPTH): memory address width.
REQ-003 Parameter ALPHA_SHIFT, default 3: PReLU slope is 2^-ALPHA_SHIFT (range 1..7).
REQ-004 clk  input  1  sole clock; all state on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  job request; accepted only in IDLE or DONE.
REQ-007 fn_sel  input  3  activation select; sampled with an accepted start.
REQ-008 in_valid  input  1  x carries a valid IEEE-754 single.
REQ-009 in_ready  output  1  block accepts x this cycle.
REQ-010 x  input  32  input operand.
REQ-011 mem_cen  output  1  SRAM chip enable, active-low.
REQ-012 mem_wen  output  1  SRAM write enable, active-low.
REQ-013 mem_addr  output  AW  SRAM word address.
REQ-014 mem_d  output  32  SRAM write data.
REQ-015 busy  output  1  high while a job is in progress.
REQ-016 done  output  1  high from job completion until the next accepted start.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN and DONE->RUN on start; RUN->DONE on the cycle the DEPTH-th write issues.
REQ-018 start in RUN SHALL be ignored; fn_sel changes during RUN SHALL have no effect.
REQ-019 in_ready SHALL equal (state==RUN) and (accepted count < DEPTH).
REQ-020 A transfer SHALL occur when in_valid and in_ready are both high; x registers on that edge.
REQ-021 Each accepted x SHALL be written exactly 1 cycle later: mem_cen=0, mem_wen=0, mem_d=f(x), mem_addr=write index.
REQ-022 mem_cen and mem_wen SHALL be 1 in every cycle without a write; mem_d SHALL be 0 in those cycles.
REQ-023 Write index SHALL start at 0 on accepted start, increment by 1 after each write, and never exceed DEPTH-1.
REQ-024 Back-to-back transfers SHALL sustain one write per cycle; in_valid gaps SHALL insert idle cycles without losing or reordering data.
REQ-025 fn_sel 0 (PReLU): x>=0 -> x; x<0 -> sign kept, exponent reduced by ALPHA_SHIFT, mantissa kept.
REQ-026 PReLU with negative x and 0<exponent<=ALPHA_SHIFT SHALL produce 32'h8000_0000.
REQ-027 fn_sel 1 (ReLU): sign 0 -> x; sign 1 -> 32'h0000_0000.
REQ-028 fn_sel 2 (identity): output SHALL equal x.
REQ-029 fn_sel 3 (abs): output SHALL equal x with the sign bit cleared.
REQ-030 fn_sel 4..7 SHALL produce 32'h0000_0000.
REQ-031 For every function, exponent 0 (zero or denormal) and exponent 255 (Inf or NaN) inputs SHALL pass through unchanged, except that ReLU and abs still apply their sign rules.
REQ-032 busy SHALL equal (state==RUN).
REQ-033 done SHALL rise in the cycle after the final write and fall on the cycle after an accepted start.

Reset
REQ-034 Assertion of rst SHALL immediately force state IDLE, count 0, index 0, in_ready 0, busy 0, done 0, mem_cen 1, mem_wen 1, mem_addr 0, mem_d 0.
REQ-035 Reset during RUN SHALL discard any pending write; no SRAM access SHALL occur until the next accepted start.
REQ-036 Deassertion of rst SHALL take effect synchronously to clk; start is first honoured on the following edge.

Structure
REQ-037 Package afe_pkg SHALL hold the fn_sel code constants (FN_PRELU=0, FN_RELU=1, FN_ID=2, FN_ABS=3) and the state enumeration.
REQ-038 The combinational activation SHALL be a sub-module afe_fn_unit, with ALPHA_SHIFT as a parameter, fn_sel and x as inputs, and a 32-bit result as output.
REQ-039 afe_stream SHALL contain the FSM, handshake, counters, pipeline register and SRAM port; no SRAM instance inside.

Verification
REQ-040 DEPTH=4, fn_sel=0, in_valid held high, x = 3F80_0000, BF80_0000, C000_0000, 0000_0000 -> writes to addr 0..3 of 3F80_0000, BE00_0000, BE80_0000, 0000_0000; done rises the cycle after the addr-3 write.
REQ-041 fn_sel=0, ALPHA_SHIFT=3, x=8180_0000 (exponent 3) -> 8000_0000; x=FF80_0000 -> FF80_0000.
REQ-042 fn_sel=1, 2, 3, 5 with x=C040_0000 -> 0000_0000, C040_0000, 4040_0000, 0000_0000 respectively.
REQ-043 in_valid pattern 1,0,0,1,1 -> writes appear only one cycle after each high, at consecutive addresses 0,1,2; in_ready drops after the DEPTH-th accept.
REQ-044 rst pulled low after 2 of 4 writes -> all outputs at reset values within the same cycle; a new start rewrites from addr 0.
REQ-045 start pulsed during RUN, and fn_sel toggled during RUN -> no address restart, and the function stays as sampled at start.

Source files
------------

// File: rtl/afe_pkg.sv
// rtl/afe_pkg.sv - shared activation codes and FSM state type for afe_stream
package afe_pkg;

   localparam logic [2:0] FN_PRELU = 3'd0;
   localparam logic [2:0] FN_RELU  = 3'd1;
   localparam logic [2:0] FN_ID    = 3'd2;
   localparam logic [2:0] FN_ABS   = 3'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/afe_stream_if.sv
// rtl/afe_stream_if.sv - valid/ready operand stream into afe_stream
interface afe_stream_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;

   modport master (output in_valid, output x, input in_ready);
   modport slave  (input in_valid, input x, output in_ready);

endinterface

// File: rtl/afe_fn_unit.sv
// rtl/afe_fn_unit.sv - combinational float activation (PReLU, ReLU, identity, abs)
module afe_fn_unit
   import afe_pkg::*;
#(
   parameter int ALPHA_SHIFT = 3
) (
   input  logic [2:0]  fn_sel,
   input  logic [31:0] x,
   output logic [31:0] y
);

   logic       sgn;
   logic [7:0] expo;
   logic       special;

   assign sgn     = x[31];
   assign expo    = x[30:23];
   assign special = (expo == 8'd0) || (expo == 8'hFF);

   always_comb begin
      y = 32'h0000_0000;
      case (fn_sel)
         FN_PRELU: begin
            // Negative slope is a pure exponent decrement; underflow flushes to -0.
            if (special || !sgn)
               y = x;
            else if (expo <= 8'(ALPHA_SHIFT))
               y = 32'h8000_0000;
            else
               y = {sgn, expo - 8'(ALPHA_SHIFT), x[22:0]};
         end
         FN_RELU: y = sgn ? 32'h0000_0000 : x;
         FN_ID:   y = x;
         FN_ABS:  y = {1'b0, x[30:0]};
         default: y = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/afe_stream.sv
// rtl/afe_stream.sv - job FSM streaming activated operands into an external SRAM port
module afe_stream
   import afe_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int AW          = $clog2(DEPTH),
   parameter int ALPHA_SHIFT = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [2:0]    fn_sel,
   afe_stream_if.slave   in_s,
   output logic          mem_cen,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_d,
   output logic          busy,
   output logic          done
);

   localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

   state_e        state_q, state_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [2:0]    fn_q, fn_d;
   logic          in_ready_q, in_ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          mem_cen_q, mem_cen_d;
   logic          mem_wen_q, mem_wen_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]   mem_d_q, mem_d_d;
   logic [31:0]   fn_y;
   logic          xfer;
   logic          start_ok;
   logic          last_wr;

   afe_fn_unit #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_fn (
      .fn_sel (fn_q),
      .x      (in_s.x),
      .y      (fn_y)
   );

   always_comb begin
      xfer       = in_s.in_valid && in_ready_q;
      start_ok   = start && (state_q != RUN);
      last_wr    = !mem_cen_q && (cnt_q == CNT_MAX);
      state_d    = state_q;
      cnt_d      = cnt_q;
      fn_d       = fn_q;
      mem_addr_d = mem_addr_q;
      mem_cen_d  = 1'b1;
      mem_wen_d  = 1'b1;
      mem_d_d    = 32'h0000_0000;
      if (start_ok) begin
         state_d    = RUN;
         cnt_d      = '0;
         mem_addr_d = '0;
         fn_d       = fn_sel;
      end else if (state_q == RUN) begin
         // The accepted operand is activated and registered straight into the write port.
         if (xfer) begin
            cnt_d      = cnt_q + 1'b1;
            mem_cen_d  = 1'b0;
            mem_wen_d  = 1'b0;
            mem_d_d    = fn_y;
            mem_addr_d = cnt_q[AW-1:0];
         end
         if (last_wr)
            state_d = DONE;
      end
      in_ready_d = (state_d == RUN) && (cnt_d < CNT_MAX);
      busy_d     = (state_d == RUN);
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         fn_q       <= FN_PRELU;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mem_cen_q  <= 1'b1;
         mem_wen_q  <= 1'b1;
         mem_addr_q <= '0;
         mem_d_q    <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fn_q       <= fn_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mem_cen_q  <= mem_cen_d;
         mem_wen_q  <= mem_wen_d;
         mem_addr_q <= mem_addr_d;
         mem_d_q    <= mem_d_d;
      end
   end

   assign in_s.in_ready = in_ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign mem_cen       = mem_cen_q;
   assign mem_wen       = mem_wen_q;
   assign mem_addr      = mem_addr_q;
   assign mem_d         = mem_d_q;

endmodule

// File: tb/tb_afe_stream.sv
// tb/tb_afe_stream.sv - directed self-checking bench for afe_stream (DEPTH=4, ALPHA_SHIFT=3)
module tb_afe_stream;
   import afe_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    fn_sel = 3'd0;
   logic          mem_cen;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_d;
   logic          busy;
   logic          done;

   afe_stream_if sif ();

   afe_stream #(.DEPTH(DEPTH), .AW(AW), .ALPHA_SHIFT(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .fn_sel   (fn_sel),
      .in_s     (sif.slave),
      .mem_cen  (mem_cen),
      .mem_wen  (mem_wen),
      .mem_addr (mem_addr),
      .mem_d    (mem_d),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int idle_bad = 0;
   int done_rise = -1;
   logic done_prev = 1'b0;
   logic [AW-1:0] wa_q[$];
   logic [31:0]   wd_q[$];
   int            wc_q[$];

   always @(posedge clk) cyc = cyc + 1;

   // Write-port monitor: records every SRAM write and flags malformed idle cycles.
   always @(negedge clk) begin
      if (mem_cen === 1'b0) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_d);
         wc_q.push_back(cyc);
         if (mem_wen !== 1'b0) idle_bad = idle_bad + 1;
      end else if (mem_wen !== 1'b1 || mem_d !== 32'h0) begin
         idle_bad = idle_bad + 1;
      end
      if (done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
      done_prev = done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycles=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      done_rise = -1;
   endtask

   task automatic do_start(input logic [2:0] fn);
      @(negedge clk);
      start  = 1'b1;
      fn_sel = fn;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic feed(input logic [31:0] xs [4], input int n, input logic [7:0] pat, input int plen);
      int i = 0;
      int k = 0;
      logic rdy;
      while (i < n && k < 40) begin
         sif.in_valid = (k < plen) ? pat[k] : 1'b1;
         sif.x        = xs[i];
         rdy          = sif.in_ready;
         @(negedge clk);
         if (sif.in_valid && rdy) i++;
         k++;
      end
      sif.in_valid = 1'b0;
      if (i < n) begin
         vectors++;
         miscompares++;
         $display("FAIL feed_timeout accepted=%0d required=%0d", i, n);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL done_timeout done=%b required=1", done);
      end
   endtask

   task automatic test_reset();
      #12;
      vectors += 7;
      if (mem_cen !== 1'b1)      begin miscompares++; $display("FAIL rst_cen got=%b exp=1", mem_cen); end
      if (mem_wen !== 1'b1)      begin miscompares++; $display("FAIL rst_wen got=%b exp=1", mem_wen); end
      if (mem_addr !== 2'd0)     begin miscompares++; $display("FAIL rst_addr got=%0d exp=0", mem_addr); end
      if (mem_d !== 32'h0)       begin miscompares++; $display("FAIL rst_d got=%h exp=0", mem_d); end
      if (busy !== 1'b0)         begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (done !== 1'b0)         begin miscompares++; $display("FAIL rst_done got=%b exp=0", done); end
      if (sif.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b exp=0", sif.in_ready); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_prelu_job();
      logic [31:0] xs [4]  = '{32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000, 32'h0000_0000};
      logic [31:0] exp [4] = '{32'h3F80_0000, 32'hBE00_0000, 32'hBE80_0000, 32'h0000_0000};
      clear_mon();
      do_start(FN_PRELU);
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL prelu_busy got=%b exp=1", busy); end
      feed(xs, 4, 8'hFF, 8);
      wait_done();
      vectors++;
      if (wa_q.size() != 4) begin miscompares++; $display("FAIL prelu_nwrites got=%0d exp=4", wa_q.size()); end
      for (int i = 0; i < 4; i++) begin
         vectors += 3;
         if (i >= wa_q.size() || wa_q[i] !== AW'(i)) begin miscompares++; $display("FAIL prelu_addr%0d got=%0d exp=%0d", i, (i < wa_q.size()) ? wa_q[i] : 2'bx, i); end
         if (i >= wd_q.size() || wd_q[i] !== exp[i]) begin miscompares++; $display("FAIL prelu_data%0d got=%h exp=%h", i, (i < wd_q.size()) ? wd_q[i] : 32'hx, exp[i]); end
         if (i >= wc_q.size() || wc_q[i] !== wc_q[0] + i) begin miscompares++; $display("FAIL prelu_b2b%0d got=%0d exp=%0d", i, (i < wc_q.size()) ? wc_q[i] : -1, wc_q[0] + i); end
      end
      vectors += 3;
      if (wc_q.size() == 4 && done_rise !== wc_q[3] + 1) begin miscompares++; $display("FAIL prelu_done_cycle got=%0d exp=%0d", done_rise, wc_q[3] + 1); end
      if (busy !== 1'b0)         begin miscompares++; $display("FAIL prelu_busy_end got=%b exp=0", busy); end
      if (sif.in_ready !== 1'b0) begin miscompares++; $display("FAIL prelu_ready_end got=%b exp=0", sif.in_ready); end
   endtask

   task automatic test_prelu_edges();
      logic [31:0] xs [4]  = '{32'h8180_0000, 32'hFF80_0000, 32'h8000_0001, 32'h8200_0000};
      logic [31:0] exp [4] = '{32'h8000_0000, 32'hFF80_0000, 32'h8000_0001, 32'h8080_0000};
      clear_mon();
      do_start(FN_PRELU);
      feed(xs, 4, 8'hFF, 8);
      wait_done();
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (i >= wd_q.size() || wd_q[i] !== exp[i]) begin miscompares++; $display("FAIL prelu_edge%0d got=%h exp=%h", i, (i < wd_q.size()) ? wd_q[i] : 32'hx, exp[i]); end
      end
   endtask

   task automatic test_functions();
      logic [31:0] xs [4]    = '{32'hC040_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h4120_0000};
      logic [2:0]  fns [4]   = '{3'd1, 3'd2, 3'd3, 3'd5};
      logic [31:0] exp [4][4] = '{
         '{32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h4120_0000},
         '{32'hC040_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h4120_0000},
         '{32'h4040_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h4120_0000},
         '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000}};
      for (int f = 0; f < 4; f++) begin
         clear_mon();
         vectors++;
         if (done !== 1'b1) begin miscompares++; $display("FAIL fn%0d_done_before got=%b exp=1", fns[f], done); end
         do_start(fns[f]);
         vectors++;
         if (done !== 1'b0) begin miscompares++; $display("FAIL fn%0d_done_cleared got=%b exp=0", fns[f], done); end
         feed(xs, 4, 8'hFF, 8);
         wait_done();
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= wd_q.size() || wd_q[i] !== exp[f][i]) begin miscompares++; $display("FAIL fn%0d_data%0d got=%h exp=%h", fns[f], i, (i < wd_q.size()) ? wd_q[i] : 32'hx, exp[f][i]); end
         end
      end
   endtask

   task automatic test_gaps();
      logic [31:0] xs [4] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
      clear_mon();
      do_start(FN_ID);
      feed(xs, 4, 8'b0001_1001, 5);
      vectors++;
      if (sif.in_ready !== 1'b0) begin miscompares++; $display("FAIL gap_ready_after_last got=%b exp=0", sif.in_ready); end
      sif.in_valid = 1'b1;
      sif.x        = 32'hDEAD_BEEF;
      wait_done();
      repeat (2) @(negedge clk);
      sif.in_valid = 1'b0;
      vectors++;
      if (wa_q.size() != 4) begin miscompares++; $display("FAIL gap_nwrites got=%0d exp=4", wa_q.size()); end
      for (int i = 0; i < 4; i++) begin
         vectors += 2;
         if (i >= wa_q.size() || wa_q[i] !== AW'(i) || wd_q[i] !== xs[i]) begin miscompares++; $display("FAIL gap_write%0d got=%0d/%h exp=%0d/%h", i, (i < wa_q.size()) ? wa_q[i] : 2'bx, (i < wd_q.size()) ? wd_q[i] : 32'hx, i, xs[i]); end
         if (wc_q.size() == 4 && wc_q[i] !== wc_q[0] + ((i == 0) ? 0 : i + 2)) begin miscompares++; $display("FAIL gap_cycle%0d got=%0d exp=%0d", i, wc_q[i], wc_q[0] + ((i == 0) ? 0 : i + 2)); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] xs [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      clear_mon();
      do_start(FN_ID);
      feed(xs, 2, 8'hFF, 8);
      #2 rst = 1'b0;
      #1;
      vectors += 7;
      if (mem_cen !== 1'b1)      begin miscompares++; $display("FAIL mid_cen got=%b exp=1", mem_cen); end
      if (mem_wen !== 1'b1)      begin miscompares++; $display("FAIL mid_wen got=%b exp=1", mem_wen); end
      if (mem_addr !== 2'd0)     begin miscompares++; $display("FAIL mid_addr got=%0d exp=0", mem_addr); end
      if (mem_d !== 32'h0)       begin miscompares++; $display("FAIL mid_d got=%h exp=0", mem_d); end
      if (busy !== 1'b0)         begin miscompares++; $display("FAIL mid_busy got=%b exp=0", busy); end
      if (done !== 1'b0)         begin miscompares++; $display("FAIL mid_done got=%b exp=0", done); end
      if (sif.in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready got=%b exp=0", sif.in_ready); end
      @(negedge clk);
      rst = 1'b1;
      sif.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      sif.in_valid = 1'b0;
      vectors += 2;
      if (wa_q.size() != 2)      begin miscompares++; $display("FAIL mid_no_access got=%0d exp=2", wa_q.size()); end
      if (sif.in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_idle_ready got=%b exp=0", sif.in_ready); end
      clear_mon();
      do_start(FN_ID);
      feed(xs, 4, 8'hFF, 8);
      wait_done();
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (i >= wa_q.size() || wa_q[i] !== AW'(i) || wd_q[i] !== xs[i]) begin miscompares++; $display("FAIL mid_rerun%0d got=%0d/%h exp=%0d/%h", i, (i < wa_q.size()) ? wa_q[i] : 2'bx, (i < wd_q.size()) ? wd_q[i] : 32'hx, i, xs[i]); end
      end
   endtask

   task automatic test_start_in_run();
      logic [31:0] xs [4]  = '{32'hBF80_0000, 32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000};
      logic [31:0] exp [4] = '{32'hBE00_0000, 32'hBE80_0000, 32'h3F80_0000, 32'hBE00_0000};
      clear_mon();
      do_start(FN_PRELU);
      start  = 1'b1;
      fn_sel = FN_ID;
      feed(xs, 4, 8'hFF, 8);
      start  = 1'b0;
      wait_done();
      vectors += 2;
      if (wa_q.size() != 4) begin miscompares++; $display("FAIL run_nwrites got=%0d exp=4", wa_q.size()); end
      if (wc_q.size() == 4 && done_rise !== wc_q[3] + 1) begin miscompares++; $display("FAIL run_done_cycle got=%0d exp=%0d", done_rise, wc_q[3] + 1); end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (i >= wa_q.size() || wa_q[i] !== AW'(i) || wd_q[i] !== exp[i]) begin miscompares++; $display("FAIL run_write%0d got=%0d/%h exp=%0d/%h", i, (i < wa_q.size()) ? wa_q[i] : 2'bx, (i < wd_q.size()) ? wd_q[i] : 32'hx, i, exp[i]); end
      end
   endtask

   task automatic test_idle_bus();
      vectors++;
      if (idle_bad != 0) begin miscompares++; $display("FAIL idle_bus_violations got=%0d exp=0", idle_bad); end
   endtask

   initial begin
      sif.in_valid = 1'b0;
      sif.x        = 32'h0;
      test_reset();
      test_prelu_job();
      test_prelu_edges();
      test_functions();
      test_gaps();
      test_reset_mid();
      test_start_in_run();
      test_idle_bus();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
